pc_gen: RTL and testbench

//  Parametrised program-counter generator for the fetch stage. It holds the PC and picks the

---
 rtl/pc_gen_if.sv | 27 ++
 rtl/pc_gen.sv | 130 +++++++++++++
 tb/tb_pc_gen.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Fetch-side control bundle between the branch/hazard logic (master) and the PC generator (slave).
interface pc_gen_if #(
  parameter int XLEN = 32
);
  logic            enable;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            branch_taken;
  logic [XLEN-1:0] branch_target;
  logic            call;
  logic            ret;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus;
  logic            misaligned;
  logic            ras_empty;
  logic            ras_full;

  modport master (
    output enable, redirect_valid, redirect_target, branch_taken, branch_target, call, ret,
    input  pc, pc_plus, misaligned, ras_empty, ras_full
  );

  modport slave (
    input  enable, redirect_valid, redirect_target, branch_taken, branch_target, call, ret,
    output pc, pc_plus, misaligned, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator: picks next PC from redirect, RAS, branch or sequential flow.
// Define PC_RAS_EN to build the return-address stack; otherwise ret falls back to branch_target.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              INSTR_BYTES  = 4,
  parameter int              RAS_DEPTH    = 4
) (
  input logic     clk,
  input logic     reset,
  pc_gen_if.slave bus
);
  localparam int              OFF_W      = $clog2(INSTR_BYTES);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

  logic [XLEN-1:0] pc_reg, pc_next;
  logic            misaligned_reg, misaligned_next;
  logic [XLEN-1:0] pc_plus;
  logic [XLEN-1:0] target;
  logic            take_target;
  logic            hold;
  logic            ras_empty_w;
  logic            ras_full_w;

  assign pc_plus = pc_reg + XLEN'(INSTR_BYTES);

`ifdef PC_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_reg, top_next;
  logic [PTR_W:0]   count_reg, count_next;
  logic             ras_we;
  logic [PTR_W-1:0] ras_waddr;
  logic             ras_upd;

  assign ras_empty_w = (count_reg == '0);
  assign ras_full_w  = (count_reg == (PTR_W + 1)'(RAS_DEPTH));
  assign ras_upd     = bus.enable && !bus.redirect_valid;

  always_comb begin
    top_next   = top_reg;
    count_next = count_reg;
    ras_we     = 1'b0;
    ras_waddr  = top_reg;
    if (ras_upd) begin
      case ({bus.call, bus.ret})
        2'b10: begin
          // Circular push: on a full stack the oldest slot is the one overwritten.
          ras_we     = 1'b1;
          ras_waddr  = top_reg + PTR_W'(1);
          top_next   = top_reg + PTR_W'(1);
          count_next = ras_full_w ? count_reg : count_reg + (PTR_W + 1)'(1);
        end
        2'b01: begin
          if (!ras_empty_w) begin
            top_next   = top_reg - PTR_W'(1);
            count_next = count_reg - (PTR_W + 1)'(1);
          end
        end
        2'b11: begin
          ras_we = 1'b1;
          if (ras_empty_w) count_next = (PTR_W + 1)'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_reg   <= '0;
      count_reg <= '0;
    end else begin
      top_reg   <= top_next;
      count_reg <= count_next;
    end
  end

  // Stack contents need no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (ras_we) ras_mem[ras_waddr] <= pc_plus;
  end
`else
  wire unused_cfg = bus.call & (RAS_DEPTH > 1);

  assign ras_empty_w = 1'b1;
  assign ras_full_w  = 1'b0;
`endif

  always_comb begin
    target      = pc_plus;
    take_target = 1'b0;
    hold        = 1'b0;
    if (bus.redirect_valid) begin
      target      = bus.redirect_target;
      take_target = 1'b1;
    end else if (!bus.enable) begin
      hold = 1'b1;
`ifdef PC_RAS_EN
    end else if (bus.ret && !ras_empty_w) begin
      target      = ras_mem[top_reg];
      take_target = 1'b1;
`endif
    end else if (bus.ret || bus.branch_taken) begin
      target      = bus.branch_target;
      take_target = 1'b1;
    end
  end

  // Sequential flow is always aligned, so only explicit targets can flag.
  assign misaligned_next = take_target && (|target[OFF_W-1:0]);
  assign pc_next         = hold ? pc_reg : (target & ALIGN_MASK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg         <= RESET_VECTOR;
      misaligned_reg <= 1'b0;
    end else begin
      pc_reg         <= pc_next;
      misaligned_reg <= misaligned_next;
    end
  end

  assign bus.pc         = pc_reg;
  assign bus.pc_plus    = pc_plus;
  assign bus.misaligned = misaligned_reg;
  assign bus.ras_empty  = ras_empty_w;
  assign bus.ras_full   = ras_full_w;
endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a queue-based return-stack model predicts each cycle's outputs.
module tb_pc_gen;
  localparam int          XLEN  = 32;
  localparam logic [31:0] RV    = 32'h100;
  localparam int          IB    = 4;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(XLEN)) bus ();

  pc_gen #(
    .XLEN(XLEN), .RESET_VECTOR(RV), .INSTR_BYTES(IB), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic        mis;
    logic        emp;
    logic        full;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  logic [31:0] m_pc;
  logic        m_mis;
  logic [31:0] m_ras[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_empty();
`ifdef PC_RAS_EN
    return m_ras.size() == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic m_full();
`ifdef PC_RAS_EN
    return m_ras.size() == DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_pc  = RV;
    m_mis = 1'b0;
    m_ras.delete();
  endtask

  // Next-state rules written directly from the priority list, using a plain queue as the stack.
  task automatic model_step(input logic en, input logic rv, input logic [31:0] rt,
                            input logic bt, input logic [31:0] bta, input logic c, input logic r);
    logic [31:0] tgt;
    logic        jump;
    logic [31:0] ret_addr;
    ret_addr = m_pc + IB;
    jump     = 1'b0;
    tgt      = m_pc + IB;
    if (rv) begin
      tgt  = rt;
      jump = 1'b1;
    end else if (!en) begin
      tgt = m_pc;
    end else begin
`ifdef PC_RAS_EN
      if (r && m_ras.size() > 0) begin
        tgt  = m_ras[$];
        jump = 1'b1;
      end else if (r || bt) begin
        tgt  = bta;
        jump = 1'b1;
      end
      if (c && !r) begin
        m_ras.push_back(ret_addr);
        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
      end else if (r && !c) begin
        if (m_ras.size() > 0) void'(m_ras.pop_back());
      end else if (c && r) begin
        if (m_ras.size() > 0) m_ras[m_ras.size() - 1] = ret_addr;
        else m_ras.push_back(ret_addr);
      end
`else
      if (r || bt) begin
        tgt  = bta;
        jump = 1'b1;
      end
`endif
    end
    m_mis = jump && (tgt % IB != 0);
    m_pc  = tgt - (tgt % IB);
  endtask

  task automatic step(input logic en, input logic rv, input logic [31:0] rt,
                      input logic bt, input logic [31:0] bta, input logic c, input logic r);
    exp_t e;
    @(negedge clk);
    bus.enable          = en;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    bus.branch_taken    = bt;
    bus.branch_target   = bta;
    bus.call            = c;
    bus.ret             = r;
    model_step(en, rv, rt, bt, bta, c, r);
    e.pc   = m_pc;
    e.mis  = m_mis;
    e.emp  = m_empty();
    e.full = m_full();
    sb.push_back(e);
    $display("step en=%0b rv=%0b rt=%h bt=%0b bta=%h call=%0b ret=%0b -> exp pc=%h mis=%0b",
             en, rv, rt, bt, bta, c, r, e.pc, e.mis);
  endtask

  task automatic idle_inputs();
    bus.enable          = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.branch_taken    = 1'b0;
    bus.branch_target   = '0;
    bus.call            = 1'b0;
    bus.ret             = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("pc", bus.pc, mon_e.pc);
        chk("pc_plus", bus.pc_plus, mon_e.pc + IB);
        chk("misaligned", 32'(bus.misaligned), 32'(mon_e.mis));
        chk("ras_empty", 32'(bus.ras_empty), 32'(mon_e.emp));
        chk("ras_full", 32'(bus.ras_full), 32'(mon_e.full));
      end
    end
  end

  initial begin
    logic [31:0] t;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", bus.pc, RV);
    chk("reset_mis", 32'(bus.misaligned), 32'd0);
    chk("reset_empty", 32'(bus.ras_empty), 32'd1);
    chk("reset_full", 32'(bus.ras_full), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Sequential run from reset vector
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    // Redirect while stalled, then hold
    step(0, 1, 32'h400, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h80, 1, 0);
    // Misaligned branch, then sequential
    step(1, 0, 0, 1, 32'h202, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    // Nested calls and returns
    step(0, 1, 32'h10, 0, 0, 0, 0);
    step(1, 0, 0, 1, 32'h20, 1, 0);
    step(1, 0, 0, 1, 32'h30, 1, 0);
    step(1, 0, 0, 1, 32'h40, 1, 0);
    repeat (3) step(1, 0, 0, 0, 32'h900, 0, 1);
    // Overflow: five calls, then five returns
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 32'h1000 + 32'(i) * 32'h100, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 32'h2000, 0, 1);
    // Call and return together, on empty and non-empty stacks
    step(1, 0, 0, 1, 32'h3000, 1, 1);
    step(1, 0, 0, 1, 32'h3100, 1, 0);
    step(1, 0, 0, 1, 32'h3200, 1, 1);
    step(1, 1, 32'h3303, 1, 32'h3400, 1, 0);
    step(1, 0, 0, 0, 32'h3500, 0, 1);
    // Wrap at the top of the address space
    step(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset during a stall, held across an edge with a redirect pending
    step(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_reset_pc", bus.pc, RV);
    chk("async_reset_empty", 32'(bus.ras_empty), 32'd1);
    chk("async_reset_mis", 32'(bus.misaligned), 32'd0);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h777;
    bus.enable          = 1'b1;
    bus.call            = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_override_pc", bus.pc, RV);
    chk("reset_override_full", 32'(bus.ras_full), 32'd0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      t = $urandom;
      if ($urandom_range(0, 2) != 0) t[1:0] = 2'b00;
      step($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, t,
           $urandom_range(0, 3) == 0, {$urandom_range(0, 4095), 2'($urandom_range(0, 3))} & 32'hFFFF_FFF0 | 32'($urandom_range(0, 1) * 2),
           $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
    end

    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
